// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational IF-stage lookup and registered ID-stage resolution/flush.
module branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 64,
  parameter int DELAY_SLOT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_uncond,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_pred_taken,
  input  logic [ADDR_WIDTH-1:0] upd_pred_target,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam logic [ADDR_WIDTH-1:0] SEQ_OFF  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] FALL_OFF =
    (DELAY_SLOT != 0) ? ADDR_WIDTH'(8) : ADDR_WIDTH'(4);

  logic                  tbl_valid  [ENTRIES];
  logic [TAG_W-1:0]      tbl_tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0] tbl_target [ENTRIES];
  logic [1:0]            tbl_ctr    [ENTRIES];

  // Lookup side reads only registered table state, so an update landing on
  // the same index this cycle becomes visible one cycle later.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[ADDR_WIDTH-1:IDX_W+2];
  assign lk_hit = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit && tbl_ctr[lk_idx][1];
  assign pred_target = pred_taken ? tbl_target[lk_idx] : (lookup_pc + SEQ_OFF);

  // Update handshake: upd_valid is a one-cycle strobe with no ready/back-pressure;
  // every cycle it is high (and rst is low) is consumed at that rising edge.
  logic [IDX_W-1:0]      up_idx;
  logic [TAG_W-1:0]      up_tag;
  logic                  up_hit;
  logic                  actual_taken;
  logic                  mp_cond;
  logic                  write_en;
  logic [1:0]            ctr_next;
  logic [ADDR_WIDTH-1:0] redirect_next;

  assign up_idx       = upd_pc[IDX_W+1:2];
  assign up_tag       = upd_pc[ADDR_WIDTH-1:IDX_W+2];
  assign up_hit       = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);
  assign actual_taken = upd_taken || upd_uncond;
  assign write_en     = upd_valid && (up_hit || actual_taken);

  assign mp_cond = (actual_taken != upd_pred_taken) ||
                   (actual_taken && upd_pred_taken && (upd_pred_target != upd_target));

  assign redirect_next = actual_taken ? upd_target : (upd_pc + FALL_OFF);

  always_comb begin
    ctr_next = tbl_ctr[up_idx];
    if (!up_hit) begin
      ctr_next = upd_uncond ? 2'b11 : 2'b10;
    end else if (upd_uncond) begin
      ctr_next = 2'b11;
    end else if (upd_taken) begin
      if (tbl_ctr[up_idx] != 2'b11) ctr_next = tbl_ctr[up_idx] + 2'd1;
    end else begin
      if (tbl_ctr[up_idx] != 2'b00) ctr_next = tbl_ctr[up_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_ctr[i]    <= 2'b01;
      end
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (write_en) begin
        tbl_valid[up_idx] <= 1'b1;
        tbl_tag[up_idx]   <= up_tag;
        tbl_ctr[up_idx]   <= ctr_next;
        if (actual_taken) tbl_target[up_idx] <= upd_target;
      end
      mispredict <= upd_valid && mp_cond;
      if (upd_valid) begin
        redirect_pc   <= redirect_next;
        stat_branches <= stat_branches + 32'd1;
        if (mp_cond) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of every address port.
REQ-002 Parameter ENTRIES, default 64: table entries; power of two, at least 4.
REQ-003 Parameter DELAY_SLOT, default 1: 1 gives fall-through = pc+8 (branch delay slot); 0 gives pc+4.
REQ-004 Derived widths: IDX_W = log2(ENTRIES); TAG_W = ADDR_WIDTH - IDX_W - 2.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 lookup_pc  in  ADDR_WIDTH  IF-stage fetch address.
REQ-009 pred_taken  out  1  predicted taken for lookup_pc (combinational).
REQ-010 pred_target  out  ADDR_WIDTH  predicted next fetch address (combinational).
REQ-011 upd_valid  in  1  ID-stage resolved control-transfer instruction this cycle.
REQ-012 upd_pc  in  ADDR_WIDTH  address of the resolved instruction.
REQ-013 upd_uncond  in  1  instruction is J/JAL/JR/JALR; always taken.
REQ-014 upd_taken  in  1  actual direction.
REQ-015 upd_target  in  ADDR_WIDTH  actual taken target.
REQ-016 upd_pred_taken  in  1  prediction made for this instruction at fetch.
REQ-017 upd_pred_target  in  ADDR_WIDTH  target predicted for this instruction at fetch.
REQ-018 mispredict  out  1  registered one-cycle flush request.
REQ-019 redirect_pc  out  ADDR_WIDTH  registered correct fetch address, valid while mispredict=1.
REQ-020 stat_branches  out  32  count of accepted updates.
REQ-021 stat_mispredicts  out  32  count of detected mispredictions.

Function
REQ-022 Each entry SHALL hold valid, tag[TAG_W], target[ADDR_WIDTH] and a 2-bit saturating counter.
REQ-023 Index = pc[IDX_W+1:2]; tag = pc[ADDR_WIDTH-1:IDX_W+2].
REQ-024 Hit = entry valid and stored tag equals lookup tag.
REQ-025 pred_taken = hit AND ctr[1].
REQ-026 pred_target = stored target when pred_taken=1, else lookup_pc+4 (modulo 2^ADDR_WIDTH).
REQ-027 Lookup SHALL read pre-edge state: a same-cycle update to the same index is not visible until the next cycle.
REQ-028 Update, when upd_valid=1 and rst=0, on an entry hit:
- conditional: counter +1 saturating at 11 if taken, -1 saturating at 00 if not taken.
- unconditional: counter forced to 11.
- target rewritten with upd_target whenever taken.
REQ-029 Update on an entry miss:
- taken: allocate and overwrite the entry (valid=1, new tag, target=upd_target); counter 11 if upd_uncond, else 10.
- not taken: no allocation; table unchanged.
REQ-030 Actual direction = upd_taken OR upd_uncond.
REQ-031 Mispredict condition:
- actual direction differs from upd_pred_taken; or
- both taken and upd_pred_target differs from upd_target.
REQ-032 On the edge where upd_valid=1, the block SHALL register:
- mispredict = mispredict condition;
- redirect_pc = upd_target if actual taken, else upd_pc + 4 + 4*DELAY_SLOT.
REQ-033 With upd_valid=0, the next edge SHALL clear mispredict and hold redirect_pc.
REQ-034 Back-to-back updates SHALL each produce an independent mispredict result (latency 1, no bubbles).
REQ-035 stat_branches SHALL increment by 1 per accepted update, and stat_mispredicts by 1 per detected misprediction, in the same edge; both wrap from 0xFFFFFFFF to 0.

Reset
REQ-036 rst=1 at an edge SHALL:
- clear all valid bits, set all counters to 01, tags and targets to 0;
- set mispredict=0, redirect_pc=0, stat_branches=0, stat_mispredicts=0.
REQ-037 An update presented in the same cycle as rst=1 SHALL be discarded.
REQ-038 Reset mid-sequence SHALL leave no residual prediction or flush.

Verification (ENTRIES=64, DELAY_SLOT=1)
REQ-039 Cold lookup: after reset, lookup_pc=0x00400000 -> pred_taken=0, pred_target=0x00400004.
REQ-040 Allocate and hit:
- update pc=0x00400010, taken, target=0x00400040, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x00400040, stats 1/1;
- then lookup 0x00400010 -> pred_taken=1, pred_target=0x00400040.
REQ-041 Hysteresis:
- from REQ-040 state, not-taken update with pred_taken=1 -> mispredict=1, redirect_pc=0x00400018;
- lookup then gives pred_taken=0 (counter 01); a further taken update restores pred_taken=1.
REQ-042 Alias: entry for 0x00400010 present; lookup 0x00400110 (same index, different tag) -> pred_taken=0, pred_target=0x00400114.
REQ-043 Read-before-write: lookup and taken-allocating update to the same pc in one cycle -> that cycle pred_taken=0; next cycle pred_taken=1.
REQ-044 Reset collision: rst=1 together with upd_valid=1 -> mispredict=0, stats 0, entry not allocated.
